// File: rtl/fetch_pkg.sv
// Types and helpers shared by the fetch unit and its branch target buffer.
package fetch_pkg;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Tag is kept full width; only the bits above the index are ever non-zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/defines.sv
// Shared pipeline-wide widths and hazard stall codes.
`ifndef DEFINES_SV
`define DEFINES_SV
`define STALL_WIDTH    2
`define STALL_NONE     2'd0
`define STALL_LOAD     2'd1
`define STALL_BRANCH   2'd2
`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`endif

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lkp_pc,
  output logic        o_hit,
  output logic        o_taken,
  output logic [31:0] o_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [1:0]             r_ctr    [BTB_ENTRIES];
  logic [31:0]            r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];

  logic [IDX-1:0] w_lkp_idx;
  logic [IDX-1:0] w_upd_idx;
  logic [31:0]    w_lkp_tag;
  logic [31:0]    w_upd_tag;
  btb_entry_t     w_lkp_ent;
  logic           w_upd_hit;
  logic           w_unused;

  assign w_lkp_idx = i_lkp_pc[IDX+1:2];
  assign w_upd_idx = i_upd_pc[IDX+1:2];
  assign w_lkp_tag = i_lkp_pc >> (IDX + 2);
  assign w_upd_tag = i_upd_pc >> (IDX + 2);
  assign w_unused  = ^{i_lkp_pc[1:0], i_upd_pc[1:0]};

  assign w_lkp_ent = '{valid:  r_valid[w_lkp_idx],
                       tag:    r_tag[w_lkp_idx],
                       target: r_target[w_lkp_idx],
                       ctr:    r_ctr[w_lkp_idx]};

  assign o_hit    = w_lkp_ent.valid && (w_lkp_ent.tag == w_lkp_tag);
  assign o_taken  = o_hit && w_lkp_ent.ctr[1];
  assign o_target = o_hit ? w_lkp_ent.target : 32'b0;

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], i_upd_taken);
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag/target carry no reset; a stray write while valid is clear is never observed.
  always_ff @(posedge clk) begin
    if (i_upd_valid && i_upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC register and next-PC selection around a BTB.
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`STALL_WIDTH-1:0]     stall,
  input  logic                        redirect,
  input  logic [`MEM_ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                        upd_valid,
  input  logic [31:0]                 upd_pc,
  input  logic                        upd_taken,
  input  logic [31:0]                 upd_target,
  output logic [`MEM_ADDR_WIDTH-1:0]  imem_addr,
  input  logic [`REG_DATA_WIDTH-1:0]  imem_rdata,
  output logic [`MEM_ADDR_WIDTH-1:0]  PC_if,
  output logic [`REG_DATA_WIDTH-1:0]  inst_if,
  output logic                        bp_if,
  output logic [31:0]                 BTB_target_if
);

  logic [`MEM_ADDR_WIDTH-1:0] pc_q;
  logic [`MEM_ADDR_WIDTH-1:0] w_pc_next;
  logic                       w_hit;
  logic                       w_hold;

  btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lkp_pc     (pc_q),
    .o_hit        (w_hit),
    .o_taken      (bp_if),
    .o_target     (BTB_target_if),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_taken  (upd_taken),
    .i_upd_target (upd_target)
  );

  assign w_hold = (stall == `STALL_LOAD) || (stall == `STALL_BRANCH);

  // Redirect beats stall, stall beats prediction.
  always_comb begin
    w_pc_next = pc_q + 32'd4;
    if (redirect)   w_pc_next = redirect_pc;
    else if (w_hold) w_pc_next = pc_q;
    else if (bp_if)  w_pc_next = BTB_target_if;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= w_pc_next;
  end

  assign imem_addr = pc_q;
  assign PC_if     = pc_q;
  assign inst_if   = imem_rdata;

  logic w_unused_hit;
  assign w_unused_hit = w_hit;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC sequencing, stalls, redirects, BTB training and reset.
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC_if;
  logic [31:0] inst_if;
  logic        bp_if;
  logic [31:0] BTB_target_if;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .PC_if         (PC_if),
    .inst_if       (inst_if),
    .bp_if         (bp_if),
    .BTB_target_if (BTB_target_if)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic visit(input logic [31:0] addr);
    redirect    = 1'b1;
    redirect_pc = addr;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    stall = `STALL_NONE; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    #3;
    check("rst_pc",  PC_if, 32'h0);
    check("rst_bp",  {31'b0, bp_if}, 32'h0);
    check("rst_tgt", BTB_target_if, 32'h0);

    // Redirect and a BTB update while in reset must both be ignored.
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h80;
    redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); @(posedge clk); #2;
    check("rst_hold_pc", PC_if, 32'h0);
    upd_valid = 1'b0; redirect = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check("rel_pc0",  PC_if, 32'h0);
    check("rel_inst", inst_if, 32'hDEAD_0000);

    step(); check("seq_pc4",  PC_if, 32'h4);  check("seq_bp4", {31'b0, bp_if}, 32'h0);
    step(); check("seq_pc8",  PC_if, 32'h8);  check("seq_bp8", {31'b0, bp_if}, 32'h0);
    step(); check("seq_pc12", PC_if, 32'hC);  check("seq_inst12", inst_if, 32'hDEAD_000C);
    step(); check("seq_pc16", PC_if, 32'h10); check("rst_upd_ignored", {31'b0, bp_if}, 32'h0);

    // Allocate 0x10 -> 0x80 while fetching 0x10: lookup sees the old contents this cycle.
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h80;
    redirect = 1'b1; redirect_pc = 32'h10;
    #1;
    check("same_cycle_old", {31'b0, bp_if}, 32'h0);
    step();
    upd_valid = 1'b0; redirect = 1'b0;
    check("alloc_pc",  PC_if, 32'h10);
    check("alloc_bp",  {31'b0, bp_if}, 32'h1);
    check("alloc_tgt", BTB_target_if, 32'h80);
    step(); check("pred_next", PC_if, 32'h80);

    // Three not-taken: 2 -> 1 -> 0 -> 0.
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0; upd_target = 32'h555;
    step(); step(); step();
    upd_valid = 1'b0;
    visit(32'h10);
    check("nt_bp",  {31'b0, bp_if}, 32'h0);
    check("nt_tgt", BTB_target_if, 32'h80);
    step(); check("nt_next", PC_if, 32'h14);

    // Taken from 0 -> 1 with new target: still predicts not-taken.
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h90;
    visit(32'h10);
    check("ctr1_bp",  {31'b0, bp_if}, 32'h0);
    check("ctr1_tgt", BTB_target_if, 32'h90);
    visit(32'h10);
    check("ctr2_bp", {31'b0, bp_if}, 32'h1);
    visit(32'h10);
    visit(32'h10);
    upd_taken = 1'b0;
    visit(32'h10);
    upd_valid = 1'b0;
    check("sat_hi_bp", {31'b0, bp_if}, 32'h1);

    stall = `STALL_BRANCH;
    step(); check("stall_over_bp", PC_if, 32'h10);
    stall = `STALL_NONE;
    step(); check("bp_redirect", PC_if, 32'h90);

    visit(32'h20); check("ld_start", PC_if, 32'h20);
    stall = `STALL_LOAD;
    step(); check("ld_hold1", PC_if, 32'h20);
    step(); check("ld_hold2", PC_if, 32'h20);
    step(); check("ld_hold3", PC_if, 32'h20);
    stall = `STALL_NONE;
    step(); check("ld_release", PC_if, 32'h24);

    stall = `STALL_BRANCH;
    visit(32'h200);
    stall = `STALL_NONE;
    check("redir_over_stall", PC_if, 32'h200);

    visit(32'hFFFF_FFFC); check("wrap_pre", PC_if, 32'hFFFF_FFFC);
    step(); check("wrap_post", PC_if, 32'h0);

    // 0x50 aliases the 0x10 entry with a different tag; not-taken miss must not allocate.
    upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b0; upd_target = 32'h123;
    step();
    upd_valid = 1'b0;
    visit(32'h50);
    check("nt_miss_bp",  {31'b0, bp_if}, 32'h0);
    check("nt_miss_tgt", BTB_target_if, 32'h0);
    visit(32'h10);
    check("alias_kept_bp",  {31'b0, bp_if}, 32'h1);
    check("alias_kept_tgt", BTB_target_if, 32'h90);

    visit(32'h40); check("mid_pc", PC_if, 32'h40);
    #1; rst = 1'b0; #1;
    check("async_rst_pc",  PC_if, 32'h0);
    check("async_rst_bp",  {31'b0, bp_if}, 32'h0);
    check("async_rst_tgt", BTB_target_if, 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    check("post_rst_pc", PC_if, 32'h0);
    visit(32'h10);
    check("post_rst_bp",  {31'b0, bp_if}, 32'h0);
    check("post_rst_tgt", BTB_target_if, 32'h0);
    step(); check("post_rst_next", PC_if, 32'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
